// File: rtl/dac_sample_scheduler.sv
// Paces two sample sources into the dual-channel DAC driver: one holding register per
// channel, frame-aligned output updates every FRAME_LEN*(rate_div+1) clocks, sticky underrun flags.
module dac_sample_scheduler #(
    parameter int         FRAME_LEN = 24,
    parameter logic [7:0] MIDSCALE  = 8'h80
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       enable,
    input  logic [7:0] rate_div,
    input  logic [7:0] ch1_data,
    input  logic       ch1_valid,
    output logic       ch1_ready,
    input  logic [7:0] ch2_data,
    input  logic       ch2_valid,
    output logic       ch2_ready,
    input  logic       clr_flags,
    output logic [7:0] data_1,
    output logic [7:0] data_2,
    output logic       frame_tick,
    output logic       sample_tick,
    output logic       underrun_1,
    output logic       underrun_2,
    output logic       busy
);
    localparam int CW = $clog2(FRAME_LEN);

    typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, RUN = 2'd2} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   frame_cnt_q, frame_cnt_d;
    logic [7:0]      div_cnt_q, div_cnt_d;
    logic [7:0]      rate_lat_q, rate_lat_d;
    logic [7:0]      hold_1_q, hold_1_d, hold_2_q, hold_2_d;
    logic            full_1_q, full_1_d, full_2_q, full_2_d;
    logic [7:0]      data_1_q, data_1_d, data_2_q, data_2_d;
    logic            ready_1_q, ready_1_d, ready_2_q, ready_2_d;
    logic            frame_tick_q, frame_tick_d, sample_tick_q, sample_tick_d;
    logic            underrun_1_q, underrun_1_d, underrun_2_q, underrun_2_d;
    logic            busy_q, busy_d;

    logic            xfer_1_s, xfer_2_s, boundary_s, load_s, urun_1_s, urun_2_s;

    // Next-state, counters, holding registers and output updates.
    always_comb begin
        state_d       = state_q;
        frame_cnt_d   = frame_cnt_q;
        div_cnt_d     = div_cnt_q;
        rate_lat_d    = rate_lat_q;
        hold_1_d      = hold_1_q;
        hold_2_d      = hold_2_q;
        full_1_d      = full_1_q;
        full_2_d      = full_2_q;
        data_1_d      = data_1_q;
        data_2_d      = data_2_q;
        frame_tick_d  = 1'b0;
        sample_tick_d = 1'b0;
        load_s        = 1'b0;
        urun_1_s      = 1'b0;
        urun_2_s      = 1'b0;
        xfer_1_s      = ch1_valid && ready_1_q;
        xfer_2_s      = ch2_valid && ready_2_q;
        boundary_s    = (frame_cnt_q == CW'(FRAME_LEN - 1));

        if ((state_q == IDLE) || !enable) begin
            // Disabling discards pending samples; nothing partial reaches the outputs.
            state_d     = ((state_q == IDLE) && enable) ? ARM : IDLE;
            frame_cnt_d = {CW{1'b0}};
            div_cnt_d   = 8'd0;
            full_1_d    = 1'b0;
            full_2_d    = 1'b0;
            data_1_d    = MIDSCALE;
            data_2_d    = MIDSCALE;
        end else begin
            frame_cnt_d = boundary_s ? {CW{1'b0}} : frame_cnt_q + CW'(1);
            if (xfer_1_s) begin
                hold_1_d = ch1_data;
                full_1_d = 1'b1;
            end else begin
                hold_1_d = hold_1_q;
            end
            if (xfer_2_s) begin
                hold_2_d = ch2_data;
                full_2_d = 1'b1;
            end else begin
                hold_2_d = hold_2_q;
            end

            if (boundary_s) begin
                frame_tick_d = 1'b1;
                case (state_q)
                    ARM: begin
                        if ((full_1_q || xfer_1_s) && (full_2_q || xfer_2_s)) begin
                            state_d    = RUN;
                            load_s     = 1'b1;
                            div_cnt_d  = 8'd0;
                            rate_lat_d = rate_div;
                        end else begin
                            state_d    = ARM;
                        end
                    end
                    RUN: begin
                        if (div_cnt_q == rate_lat_q) begin
                            load_s     = 1'b1;
                            div_cnt_d  = 8'd0;
                            rate_lat_d = rate_div;
                        end else begin
                            div_cnt_d  = div_cnt_q + 8'd1;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end else begin
                frame_tick_d = 1'b0;
            end

            // On an update a held sample wins; an empty channel may be fed straight through.
            if (load_s) begin
                sample_tick_d = 1'b1;
                if (full_1_q) begin
                    data_1_d = hold_1_q;
                    full_1_d = 1'b0;
                end else if (xfer_1_s) begin
                    data_1_d = ch1_data;
                    full_1_d = 1'b0;
                end else begin
                    urun_1_s = 1'b1;
                end
                if (full_2_q) begin
                    data_2_d = hold_2_q;
                    full_2_d = 1'b0;
                end else if (xfer_2_s) begin
                    data_2_d = ch2_data;
                    full_2_d = 1'b0;
                end else begin
                    urun_2_s = 1'b1;
                end
            end else begin
                sample_tick_d = 1'b0;
            end
        end

        underrun_1_d = urun_1_s ? 1'b1 : (clr_flags ? 1'b0 : underrun_1_q);
        underrun_2_d = urun_2_s ? 1'b1 : (clr_flags ? 1'b0 : underrun_2_q);
        busy_d       = (state_d != IDLE);
        ready_1_d    = busy_d && !full_1_d;
        ready_2_d    = busy_d && !full_2_d;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q       <= IDLE;
            frame_cnt_q   <= {CW{1'b0}};
            div_cnt_q     <= 8'd0;
            rate_lat_q    <= 8'd0;
            hold_1_q      <= 8'd0;
            hold_2_q      <= 8'd0;
            full_1_q      <= 1'b0;
            full_2_q      <= 1'b0;
            data_1_q      <= MIDSCALE;
            data_2_q      <= MIDSCALE;
            ready_1_q     <= 1'b0;
            ready_2_q     <= 1'b0;
            frame_tick_q  <= 1'b0;
            sample_tick_q <= 1'b0;
            underrun_1_q  <= 1'b0;
            underrun_2_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            frame_cnt_q   <= frame_cnt_d;
            div_cnt_q     <= div_cnt_d;
            rate_lat_q    <= rate_lat_d;
            hold_1_q      <= hold_1_d;
            hold_2_q      <= hold_2_d;
            full_1_q      <= full_1_d;
            full_2_q      <= full_2_d;
            data_1_q      <= data_1_d;
            data_2_q      <= data_2_d;
            ready_1_q     <= ready_1_d;
            ready_2_q     <= ready_2_d;
            frame_tick_q  <= frame_tick_d;
            sample_tick_q <= sample_tick_d;
            underrun_1_q  <= underrun_1_d;
            underrun_2_q  <= underrun_2_d;
            busy_q        <= busy_d;
        end
    end

    assign ch1_ready   = ready_1_q;
    assign ch2_ready   = ready_2_q;
    assign data_1      = data_1_q;
    assign data_2      = data_2_q;
    assign frame_tick  = frame_tick_q;
    assign sample_tick = sample_tick_q;
    assign underrun_1  = underrun_1_q;
    assign underrun_2  = underrun_2_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// Scoreboard bench for dac_sample_scheduler: directed stimulus queues expected updates,
// a negedge monitor checks every sample_tick and the frame_tick spacing.
module tb_dac_sample_scheduler;
    logic       clk = 1'b0;
    logic       nrst, enable, clr_flags;
    logic [7:0] rate_div, ch1_data, ch2_data;
    logic       ch1_valid, ch2_valid;
    logic       ch1_ready, ch2_ready;
    logic [7:0] data_1, data_2;
    logic       frame_tick, sample_tick, underrun_1, underrun_2, busy;

    dac_sample_scheduler #(.FRAME_LEN(24), .MIDSCALE(8'h80)) dut (
        .clk(clk), .nrst(nrst), .enable(enable), .rate_div(rate_div),
        .ch1_data(ch1_data), .ch1_valid(ch1_valid), .ch1_ready(ch1_ready),
        .ch2_data(ch2_data), .ch2_valid(ch2_valid), .ch2_ready(ch2_ready),
        .clr_flags(clr_flags), .data_1(data_1), .data_2(data_2),
        .frame_tick(frame_tick), .sample_tick(sample_tick),
        .underrun_1(underrun_1), .underrun_2(underrun_2), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [7:0]  d1;
        logic [7:0]  d2;
        logic        u1;
        logic        u2;
        logic [31:0] gap;
        logic        from_arm;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   arm_cyc = 0;
    int   last_tick = 0;
    int   last_f = -1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void push(logic [7:0] d1, logic [7:0] d2, logic u1, logic u2,
                                 int gap, logic from_arm);
        exp_t e;
        e.d1 = d1; e.d2 = d2; e.u1 = u1; e.u2 = u2; e.gap = gap; e.from_arm = from_arm;
        sb.push_back(e);
    endfunction

    // Monitor: every update is popped against the scoreboard; frame ticks must be 24 apart.
    always @(negedge clk) begin
        if (sample_tick === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_tick: data %0h/%0h, expected no update (cycle %0d)",
                         data_1, data_2, cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("data_1", {24'd0, data_1}, {24'd0, mon_e.d1});
                chk("data_2", {24'd0, data_2}, {24'd0, mon_e.d2});
                chk("underrun_1", {31'd0, underrun_1}, {31'd0, mon_e.u1});
                chk("underrun_2", {31'd0, underrun_2}, {31'd0, mon_e.u2});
                chk("tick_gap", cyc - (mon_e.from_arm ? arm_cyc : last_tick), mon_e.gap);
                chk("frame_with_sample", {31'd0, frame_tick}, 32'd1);
            end
            last_tick = cyc;
        end
        if (busy !== 1'b1) begin
            last_f = -1;
        end else if (frame_tick === 1'b1) begin
            if (last_f >= 0) chk("frame_gap", cyc - last_f, 32'd24);
            last_f = cyc;
        end
    end

    // One clock; sources advance to the next sample after each accepted transfer.
    task automatic tick();
        logic x1, x2;
        x1 = ch1_valid && ch1_ready;
        x2 = ch2_valid && ch2_ready;
        @(negedge clk);
        if (x1) ch1_data = ch1_data + 8'd1;
        if (x2) ch2_data = ch2_data + 8'd1;
    endtask

    task automatic wait_tick(string name);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (sample_tick !== 1'b1 && n < 200);
        if (sample_tick !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s: no sample_tick within 200 cycles, required one", name);
        end
    endtask

    task automatic check_idle(string tag);
        chk({tag, "_data_1"}, {24'd0, data_1}, 32'h80);
        chk({tag, "_data_2"}, {24'd0, data_2}, 32'h80);
        chk({tag, "_ready"}, {30'd0, ch1_ready, ch2_ready}, 32'd0);
        chk({tag, "_ticks"}, {30'd0, frame_tick, sample_tick}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        nrst = 1'b0; enable = 1'b0; clr_flags = 1'b0; rate_div = 8'd0;
        ch1_data = 8'h10; ch2_data = 8'h20; ch1_valid = 1'b0; ch2_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        chk("reset_underrun", {30'd0, underrun_1, underrun_2}, 32'd0);
        nrst = 1'b1;
        tick(); tick();
        check_idle("idle");

        // Basic run at rate_div = 0.
        ch1_valid = 1'b1; ch2_valid = 1'b1; enable = 1'b1; arm_cyc = cyc + 1;
        push(8'h10, 8'h20, 1'b0, 1'b0, 24, 1'b1); wait_tick("t1");
        push(8'h11, 8'h21, 1'b0, 1'b0, 24, 1'b0); wait_tick("t2");
        push(8'h12, 8'h22, 1'b0, 1'b0, 24, 1'b0); wait_tick("t3");

        // Divided rate, then a change back in the middle of a long period.
        rate_div = 8'd2;
        push(8'h13, 8'h23, 1'b0, 1'b0, 24, 1'b0); wait_tick("t4");
        push(8'h14, 8'h24, 1'b0, 1'b0, 72, 1'b0); wait_tick("t5");
        repeat (30) tick();
        rate_div = 8'd0;
        push(8'h15, 8'h25, 1'b0, 1'b0, 72, 1'b0); wait_tick("t6");
        push(8'h16, 8'h26, 1'b0, 1'b0, 24, 1'b0); wait_tick("t7");

        // Channel-2 underrun, then clear coinciding with a fresh underrun.
        ch2_valid = 1'b0;
        push(8'h17, 8'h26, 1'b0, 1'b1, 24, 1'b0); wait_tick("t8");
        push(8'h18, 8'h26, 1'b0, 1'b1, 24, 1'b0);
        repeat (23) tick();
        clr_flags = 1'b1;
        wait_tick("t9");
        clr_flags = 1'b0;
        ch2_valid = 1'b1;
        repeat (5) tick();
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        chk("clr_underrun_2", {31'd0, underrun_2}, 32'd0);
        push(8'h19, 8'h27, 1'b0, 1'b0, 24, 1'b0); wait_tick("t10");

        // Bypass: channel 1 empty, sample offered exactly on the boundary cycle.
        ch1_valid = 1'b0;
        push(8'h5A, 8'h28, 1'b0, 1'b0, 24, 1'b0);
        repeat (23) tick();
        chk("ready_1_empty", {31'd0, ch1_ready}, 32'd1);
        ch1_data = 8'h5A; ch1_valid = 1'b1;
        wait_tick("t11");
        chk("ready_1_after_bypass", {31'd0, ch1_ready}, 32'd1);
        push(8'h5B, 8'h29, 1'b0, 1'b0, 24, 1'b0); wait_tick("t12");

        // Disable with both holds full; re-enable must not see the discarded samples.
        repeat (3) tick();
        chk("ready_full", {30'd0, ch1_ready, ch2_ready}, 32'd0);
        chk("busy_run", {31'd0, busy}, 32'd1);
        enable = 1'b0;
        tick();
        check_idle("disable");
        repeat (3) tick();
        enable = 1'b1; arm_cyc = cyc + 1;
        push(8'h5D, 8'h2B, 1'b0, 1'b0, 24, 1'b1); wait_tick("t13");
        push(8'h5E, 8'h2C, 1'b0, 1'b0, 24, 1'b0); wait_tick("t14");

        // Asynchronous reset in the middle of RUN.
        repeat (5) tick();
        nrst = 1'b0;
        #1;
        check_idle("async_reset");
        chk("scoreboard_empty", sb.size(), 32'd0);
        #20;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
